// File: rtl/vpipe_pkg.sv
// Shared types for the vpipe transform family: lane op modes, lane config
// record and the per-lane reset default.
package vpipe_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INC  = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Fields are sized for the widest supported lane; users slice down to W/SHW.
  localparam int CFG_MAX_W   = 64;
  localparam int CFG_MAX_SHW = 8;

  typedef struct packed {
    mode_t                  mode;
    logic [CFG_MAX_SHW-1:0] shamt;
    logic [CFG_MAX_W-1:0]   off;
  } lane_cfg_t;

  function automatic lane_cfg_t lane_reset_cfg(input int unsigned lane);
    lane_cfg_t c;
    c.mode  = MODE_PASS;
    c.shamt = '0;
    c.off   = CFG_MAX_W'(lane + 1);
    return c;
  endfunction

endpackage

// File: rtl/xform_lane.sv
// Single-lane combinational transform: result = op(d) + off, all W-bit wrap.
module xform_lane
  import vpipe_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = 3
) (
  input  logic [W-1:0]   d,
  input  mode_t          mode,
  input  logic [SHW-1:0] shamt,
  input  logic [W-1:0]   off,
  output logic [W-1:0]   result
);

  logic [W-1:0] t;

  // Reserved mode falls through to PASS; a shift of W or more clears the word.
  always_comb begin
    t = d;
    case (mode)
      MODE_INC: t = d + W'(1);
      MODE_SHL: t = (32'(shamt) >= W) ? '0 : (d << shamt);
      default:  t = d;
    endcase
    result = t + off;
  end

endmodule

// File: rtl/multilane_xform_pipe.sv
// N-lane broadcast transform feeding a DEPTH-stage valid/ready pipeline with
// a per-lane runtime config register file.
module multilane_xform_pipe
  import vpipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 5,
  parameter int DEPTH = 2,
  parameter int SHW   = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [W-1:0]                              in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [LANES*W-1:0]                        out_data,
  input  logic                                      cfg_we,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] cfg_lane,
  input  logic [1:0]                                cfg_mode,
  input  logic [SHW-1:0]                            cfg_shamt,
  input  logic [W-1:0]                              cfg_off
);

  logic [LANES*W-1:0] xf;
  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   adv;
  logic [LANES*W-1:0] dat [DEPTH];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam lane_cfg_t RST_CFG = lane_reset_cfg(g);

    mode_t          mode_q;
    logic [SHW-1:0] shamt_q;
    logic [W-1:0]   off_q;

    // Lane selects outside 0..LANES-1 match no lane and are dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q  <= RST_CFG.mode;
        shamt_q <= RST_CFG.shamt[SHW-1:0];
        off_q   <= RST_CFG.off[W-1:0];
      end else if (cfg_we && (32'(cfg_lane) == g)) begin
        mode_q  <= mode_t'(cfg_mode);
        shamt_q <= cfg_shamt;
        off_q   <= cfg_off;
      end
    end

    xform_lane #(.W(W), .SHW(SHW)) u_lane (
      .d      (in_data),
      .mode   (mode_q),
      .shamt  (shamt_q),
      .off    (off_q),
      .result (xf[g*W +: W])
    );
  end

  // Stage k can move iff the sink is ready or some stage at or after k is empty;
  // flattened form of the recursive stall chain.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!vld[j]) adv[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else begin
      if (adv[0]) vld[0] <= in_valid;
      if (adv[0] && in_valid) dat[0] <= xf;
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) vld[k] <= vld[k-1];
        if (adv[k] && vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_multilane_xform_pipe.sv
// Directed bench for multilane_xform_pipe at W=8, LANES=5, DEPTH=2, SHW=3
// with hand-computed lane results.
module tb_multilane_xform_pipe;

  localparam int W     = 8;
  localparam int LANES = 5;
  localparam int DEPTH = 2;
  localparam int SHW   = 3;
  localparam int LW    = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic                 cfg_we;
  logic [LW-1:0]        cfg_lane;
  logic [1:0]           cfg_mode;
  logic [SHW-1:0]       cfg_shamt;
  logic [W-1:0]         cfg_off;

  int n_vec  = 0;
  int n_miss = 0;

  multilane_xform_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_lane  (cfg_lane),
    .cfg_mode  (cfg_mode),
    .cfg_shamt (cfg_shamt),
    .cfg_off   (cfg_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic [LW-1:0] lane, input logic [1:0] mode,
                                input logic [SHW-1:0] shamt, input logic [W-1:0] off);
    cfg_we    = 1'b1;
    cfg_lane  = lane;
    cfg_mode  = mode;
    cfg_shamt = shamt;
    cfg_off   = off;
    tick();
    cfg_we    = 1'b0;
  endtask

  // One beat through an idle pipe with out_ready high: two-cycle latency.
  task automatic send_beat(input string tag, input logic [W-1:0] d, input logic [LANES*W-1:0] exp_v);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check_output({tag, "_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_output({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    check_output({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_output({tag, "_data"}, 64'(out_data), 64'(exp_v));
    tick();
    check_output({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int sent;
    int rcvd;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_lane  = '0;
    cfg_mode  = '0;
    cfg_shamt = '0;
    cfg_off   = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_data", 64'(out_data), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);

    // Reset defaults: off = lane+1.
    send_beat("t1_defaults", 8'h10, 40'h15_14_13_12_11);

    apply_stimulus(3'd2, 2'd1, 3'd0, 8'h03);
    apply_stimulus(3'd3, 2'd2, 3'd2, 8'h04);
    apply_stimulus(3'd4, 2'd2, 3'd3, 8'h05);
    send_beat("t2_cfg", 8'h10, 40'h85_44_14_12_11);
    send_beat("t3_wrap", 8'hFF, 40'hFD_00_03_01_00);

    apply_stimulus(3'd4, 2'd2, 3'd7, 8'h00);
    send_beat("t3_shl7", 8'h03, 40'h80_10_07_05_04);

    // Backpressure: sink stalled for the first four cycles of the stream.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 6);
      in_data   = W'(sent + 1);
      #1;
      if (cyc == 2 || cyc == 3) begin
        check_output("t4_full_in_ready", 64'(in_ready), 64'd0);
        check_output("t4_hold_valid", 64'(out_valid), 64'd1);
        check_output("t4_hold_data", 64'(out_data), 64'h80_08_05_03_02);
      end
      if (out_valid && out_ready) begin
        check_output("t4_order", 64'(out_data[7:0]), 64'(rcvd + 2));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("t4_count", 64'(rcvd), 64'd6);
    check_output("t4_empty", 64'(out_valid), 64'd0);

    // Config write in the accept cycle applies only to later beats.
    cfg_we    = 1'b1;
    cfg_lane  = 3'd0;
    cfg_mode  = 2'd0;
    cfg_shamt = 3'd0;
    cfg_off   = 8'h20;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    check_output("t5_pre_valid", 64'(out_valid), 64'd1);
    check_output("t5_pre_lane0", 64'(out_data[7:0]), 64'h11);
    tick();
    check_output("t5_post_valid", 64'(out_valid), 64'd1);
    check_output("t5_post_lane0", 64'(out_data[7:0]), 64'h30);
    tick();
    check_output("t5_drain", 64'(out_valid), 64'd0);

    // Reset with two beats held, then an out-of-range config write.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    tick();
    in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    check_output("t6_held", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("t6_rst_valid", 64'(out_valid), 64'd0);
    check_output("t6_rst_data", 64'(out_data), 64'd0);
    check_output("t6_rst_ready", 64'(in_ready), 64'd1);
    apply_stimulus(3'd7, 2'd1, 3'd0, 8'h99);
    apply_stimulus(3'd5, 2'd2, 3'd1, 8'h77);
    out_ready = 1'b1;
    #1;
    check_output("t6_no_ghost", 64'(out_valid), 64'd0);
    send_beat("t6_defaults", 8'h10, 40'h15_14_13_12_11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multilane_xform_pipe.md
Name: multilane_xform_pipe

Overview:
Parametrised N-lane value-transform pipeline for the vpipe unit-test family.
- Each accepted input word is broadcast to LANES lanes.
- Each lane computes a runtime-configurable transform: (PASS | INC | SHL by shamt) plus a per-lane offset.
- Results travel through a DEPTH-stage valid/ready pipeline with backpressure.
- Generalises the fixed five-register transform block: width, lanes, depth and per-lane op are no longer hard-coded.

Parameters:
W, 8, data width per lane
LANES, 5, number of transform lanes (>=1)
DEPTH, 2, pipeline stages from accept to output (>=1)
SHW, 3, shift-amount width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  W  input word, broadcast to all lanes
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output this cycle
out_data  out  LANES*W  lane i result at bits [i*W +: W]
cfg_we  in  1  write lane config this cycle
cfg_lane  in  max(1,$clog2(LANES))  target lane
cfg_mode  in  2  0 PASS, 1 INC, 2 SHL, 3 reserved (treated as PASS)
cfg_shamt  in  SHW  shift amount for SHL
cfg_off  in  W  additive offset

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes only on posedge clk.
- Reset values:
  - All stage valid bits are 0, so out_valid = 0 in the cycle after rst is sampled.
  - out_data is 0.
  - in_ready is 1 after reset.
  - Lane i config is mode = PASS, shamt = 0, off = i+1 (mod 2^W).
- Reset mid-operation drops all in-flight beats. No output is produced for them.
- Transform per lane:
  - t = d (PASS), d+1 (INC), or d<<shamt (SHL).
  - shamt >= W gives t = 0.
  - result = t + off.
  - All arithmetic is W bits wrap-around; carries and shifted-out bits are discarded.
- Accept: a beat is accepted when in_valid && in_ready. The config used is the config registers' value in that cycle, i.e. pre-write if cfg_we is asserted in the same cycle.
- Config write:
  - When cfg_we = 1, lane cfg_lane gets mode, shamt and off at the clock edge.
  - cfg_lane >= LANES is ignored.
  - In-flight beats are never affected.
- Pipeline: stage k holds valid_k and LANES results.
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when !out_valid || out_ready.
  - in_ready = stage-0 advance condition. It is combinational from out_ready through the stall chain; no skid buffer is required.
  - Transform is computed in stage 0 and carried unchanged to the output.
- Latency: without stalls, a beat accepted in cycle n has out_valid = 1 in cycle n+DEPTH.
- Throughput: one beat per cycle when out_ready = 1 continuously.
- Ordering: strictly in-order, no drops, no duplicates.
  - Simultaneous accept and output in a full pipe is allowed.
  - With out_ready = 0 and the pipe full (DEPTH beats held), in_ready = 0.
- Output stability: out_data and out_valid hold stable while out_valid && !out_ready.

Decomposition:
- Shared package vpipe_pkg:
  - mode enum (PASS/INC/SHL/RSVD).
  - lane_cfg_t struct (mode, shamt, off).
  - Reset-default function returning off = i+1.
- Sub-module xform_lane: combinational single-lane transform (d, cfg -> result), instantiated LANES times in a generate loop.
- Pipeline stage registers and config register file live in the top.

Test Plan:
1. Reset defaults, W=8, LANES=5, DEPTH=2: in_data = 0x10 accepted at cycle n, out_ready = 1 -> out_valid at n+2; lanes = 0x11, 0x12, 0x13, 0x14, 0x15.
2. Configure lane2 INC off3, lane3 SHL2 off4, lane4 SHL3 off5; lanes 0/1 keep defaults; in_data = 0x10 -> 0x11, 0x12, 0x14, 0x44, 0x85.
3. Same config, in_data = 0xFF (wrap) -> 0x00, 0x01, 0x03, 0x00, 0xFD; SHL with shamt = 7, d = 0x03 -> t = 0x80.
4. Backpressure: stream 0x01..0x06 with out_ready = 0 for 4 cycles -> in_ready = 0 after 2 accepts; out_data holds stable; all 6 beats then emerge in order with no loss.
5. Config write on lane0 (off = 0x20) in the same cycle as accepting 0x10 -> that beat's lane0 = 0x11; next beat 0x10 -> lane0 = 0x30.
6. rst asserted for 1 cycle with 2 beats in flight -> out_valid = 0 next cycle; lane configs back to defaults; cfg_lane = 7 write has no effect.
